// File: rtl/fpu_32_seq_multiplier.sv
// Sequential IEEE-754 single-precision multiplier: radix-2 shift-add mantissa
// datapath (one partial product per cycle), round-to-nearest-even, flush-to-zero.
module fpu_32_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             invalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [47:0]        mcand_q, mcand_d;
    logic [47:0]        acc_q, acc_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [23:0]        mant;
    logic               guard, sticky, round_up;
    logic [24:0]        mant_r;
    logic signed [9:0]  exp_n, exp_r;
    logic [22:0]        frac_r;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign nan_a  = (ea == 8'hFF) && (fa != '0);
    assign nan_b  = (eb == 8'hFF) && (fb != '0);
    assign inf_a  = (ea == 8'hFF) && (fa == '0);
    assign inf_b  = (eb == 8'hFF) && (fb == '0);
    assign zero_a = (ea == 8'h00);
    assign zero_b = (eb == 8'h00);

    // Product of two 1.x mantissas lies in [1,4); bit 47 selects the normalising shift.
    always_comb begin
        mant   = acc_q[46:23];
        guard  = acc_q[22];
        sticky = |acc_q[21:0];
        exp_n  = exp_q;
        if (acc_q[47]) begin
            mant   = acc_q[47:24];
            guard  = acc_q[23];
            sticky = |acc_q[22:0];
            exp_n  = exp_q + 10'sd1;
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {24'd0, round_up};
        exp_r    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
        frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d  = a_q[31] ^ b_q[31];
                state_d = S_DONE;
                if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
                    result_d = 32'h7FC0_0000;
                    inv_d    = 1'b1;
                end else if (inf_a || inf_b) begin
                    result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
                end else if (zero_a || zero_b) begin
                    result_d = {a_q[31] ^ b_q[31], 31'd0};
                end else begin
                    mcand_d  = {24'd0, 1'b1, fa};
                    mplier_d = {1'b1, fb};
                    acc_d    = '0;
                    cnt_d    = '0;
                    exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    state_d  = S_MULT;
                end
            end
            S_MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (exp_r >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fpu_32_seq_multiplier.sv
// Scoreboard bench for fpu_32_seq_multiplier: directed vectors with hand-computed
// products; a negedge monitor pops expectations on each output handshake.
module tb_fpu_32_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow, underflow, invalid;

    fpu_32_seq_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inv;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          lat;
    } vec_t;

    exp_t  sb[$];
    string sb_name[$];
    vec_t  vecs[$];
    exp_t  mon_e;
    string mon_n;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic add(input string n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o, input logic u, input logic i,
                       input int lat);
        vec_t v;
        v.name = n;
        v.a    = a;
        v.b    = b;
        v.e    = '{res: r, ovf: o, unf: u, inv: i};
        v.lat  = lat;
        vecs.push_back(v);
    endtask

    // Monitor: compares at each accepted output, independent of the driver.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    mon_e = sb.pop_front();
                    mon_n = sb_name.pop_front();
                    check(mon_n, 64'({result, overflow, underflow, invalid}), 64'(mon_e));
                end
            end
        end
    end

    task automatic do_accept(input logic [31:0] a, input logic [31:0] b, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            in_valid = 1'b0;
            fail_now("accept_timeout");
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        sb.push_back(v.e);
        sb_name.push_back(v.name);
        do_accept(v.a, v.b, ok);
        if (!ok) begin
            void'(sb.pop_back());
            void'(sb_name.pop_back());
        end else begin
            lat = 0;
            while (out_valid !== 1'b1 && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        vec_t bp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;

        add("mul_1p5x2",     32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 0, 26);
        add("neg2x3",        32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0, 26);
        add("rne_1ulp_sq",   32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0, 26);
        add("tie_even_up",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 0, 26);
        add("round_carry",   32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 0, 0, 0, 26);
        add("near_max",      32'h7F000000, 32'h3F800000, 32'h7F000000, 0, 0, 0, 26);
        add("overflow",      32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 0, 26);
        add("min_norm",      32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0, 26);
        add("underflow",     32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0, 26);
        add("neg_underflow", 32'h80800000, 32'h3F000000, 32'h80000000, 0, 1, 0, 26);
        add("inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1, 1);
        add("nan_x_one",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, 1);
        add("neg_nan",       32'hFFC00000, 32'hBF800000, 32'h7FC00000, 0, 0, 1, 1);
        add("ninf_x_2",      32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0, 1);
        add("nzero_x_3",     32'h80000000, 32'h40400000, 32'h80000000, 0, 0, 0, 1);
        add("denorm_x_m2",   32'h00000001, 32'hC0000000, 32'h80000000, 0, 0, 0, 1);
        add("zero_x_inf",    32'h00000000, 32'hFF800000, 32'h7FC00000, 0, 0, 1, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({result, out_valid, overflow, underflow, invalid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);
        wait_drain();

        // Backpressure: hold the result for 10 cycles with out_ready low.
        out_ready = 1'b0;
        bp = vecs[0];
        bp.name = "bp_result";
        run_vec(bp);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold", 64'({result, overflow, underflow, invalid, out_valid, in_ready}),
                  64'({32'h40400000, 3'b000, 1'b1, 1'b0}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset pulse during MULT aborts the operation.
        do_accept(32'h3FC00000, 32'h40000000, ok);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_reset_outputs", 64'({result, out_valid, overflow, underflow, invalid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", 64'(seen), 64'd0);

        run_vec(vecs[1]);
        wait_drain();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
